debounce_sync: RTL
==================

Name: debounce_sync

Overview:
- Input-conditioning stage that sits directly upstream of the team's Level 1 gate modules (and, or, xor …).
- Takes raw asynchronous inputs (switches, buttons), synchronises each one into the clk domain, and debounces it.
- Drives clean, glitch-free levels onto the gate inputs, plus single-cycle edge strobes.
- All channels are independent and identical.

Parameters:
- N_CH, 2: number of independent input channels (gate operands a, b).
- SYNC_STAGES, 2: flip-flop depth of the synchroniser. Legal values are 2 or 3.
- STABLE_CNT, 8: consecutive cycles the synchronised input must differ from the output before the output changes. Minimum 2.

Ports:
- clk  input  1  system clock; all flops on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- din  input  N_CH  raw asynchronous inputs.
- dout  output  N_CH  debounced levels; these feed the gate inputs.
- rise  output  N_CH  one-cycle pulse when the matching dout goes 0->1.
- fall  output  N_CH  one-cycle pulse when the matching dout goes 1->0.

Behaviour:
- Reset (async assert, sync release via the normal flop path):
  - All sync flops, counters, dout, rise and fall go to 0 immediately on rst_n low.
  - They stay 0 while rst_n is low.
- Synchroniser: din[i] passes through a SYNC_STAGES flop chain; the chain output is s[i]. No logic sits between the sync flops.
- Per-channel FSM (implicit, derived from the comparison s != dout):
  - STABLE (s == dout): cnt held at 0, no pulse.
  - PENDING (s != dout), at each rising edge:
    - if cnt == STABLE_CNT-1: dout <= s, cnt <= 0, and rise or fall <= 1 according to the new value;
    - else cnt <= cnt+1.
  - Any cycle where s returns to dout: cnt <= 0 in that same edge. The state returns to STABLE and the count restarts from 0 on the next mismatch; there is no partial credit.
- rise/fall:
  - Registered, asserted exactly in the cycle dout holds its new value, deasserted the next cycle.
  - rise[i] and fall[i] are never high together.
  - Back-to-back toggles are at least STABLE_CNT cycles apart.
- Latency: din changes and stays stable before edge 1. Then s changes after edge SYNC_STAGES, and dout and the strobe change after edge SYNC_STAGES+STABLE_CNT (defaults: edge 10).
- Glitch rejection: a pulse on s shorter than STABLE_CNT cycles never reaches dout.
- Counter width is $clog2(STABLE_CNT). The counter never wraps, because it clears at STABLE_CNT-1.
- Simultaneous events: channels never interact; both may toggle in the same cycle.
- Reset mid-operation: pending counts are discarded.
- Release with din high: dout = 0 after reset, so it rises SYNC_STAGES+STABLE_CNT edges after release, with a rise pulse.
- Illegal parameters (STABLE_CNT < 2, SYNC_STAGES not 2 or 3) are flagged by a generate-time $error.

Decomposition:
- Package debounce_pkg:
  - DEF_SYNC_STAGES = 2, DEF_STABLE_CNT = 8;
  - function cnt_w(n) returning $clog2(n).
- Sub-module debounce_ch: one channel (sync chain, counter, dout/rise/fall flops). It is instantiated N_CH times in a generate loop.
- debounce_sync contains only the generate loop and the parameter checks.

Test Plan:
1. Reset behaviour: hold rst_n=0 with din=2'b11. Every output is 0 during reset. Deassert before edge 0 -> dout=2'b11 after edge 10, rise=2'b11 for exactly one cycle, and no fall pulse.
2. Clean step: din[0] goes 0->1 before edge 1, din[1]=0 -> dout[0]=1 after edge 10, rise[0] high only in cycle 10, dout[1] stays 0.
3. Glitch rejection: din[1] high for 7 cycles then low, repeated 5 times -> dout[1] stays 0 and rise/fall stay 0 throughout. Then an 8-cycle high pulse -> dout[1]=1, rise pulse, then fall STABLE_CNT cycles after s drops.
4. Bounce then settle: din[0] toggles every 3 cycles for 30 cycles, then holds 1 -> exactly one rise, 10 edges after the last toggle, and no fall.
5. Async reset mid-count: din[0]=1, assert rst_n low at cycle 6 (cnt=4) -> dout, cnt and sync flops go to 0 immediately, without waiting for a clock edge. After release, dout[0] rises a full 10 edges later.
6. Simultaneous channels: both din fall together from the steady 2'b11 state -> fall=2'b11 in the same cycle and dout=2'b00. A downstream or_ output goes 1->0 exactly once.

Source files
------------

// File: rtl/debounce_pkg.sv
// debounce_pkg
//   Shared defaults, channel state encoding and sizing helper for the
//   debounce_sync input-conditioning block.
package debounce_pkg;

    localparam int unsigned DEF_SYNC_STAGES = 2;
    localparam int unsigned DEF_STABLE_CNT  = 8;

    // STABLE: synchronised input agrees with dout.
    // PENDING: they differ and the stability counter is running.
    typedef enum logic {
        ST_STABLE  = 1'b0,
        ST_PENDING = 1'b1
    } ch_state_e;

    // Width of the per-channel stability counter (counts 0..n-1).
    function automatic int unsigned cnt_w(input int unsigned n);
        return $clog2(n);
    endfunction

endpackage

// File: rtl/debounce_ch.sv
// debounce_ch
//   One debounce channel: SYNC_STAGES-deep synchroniser, stability counter,
//   registered debounced level and one-cycle rise/fall strobes.
// Ports:
//   clk_i   - system clock, rising edge
//   rst_ni  - asynchronous active-low reset
//   din_i   - raw asynchronous input
//   dout_o  - debounced level
//   rise_o  - one-cycle pulse in the first cycle dout_o is 1
//   fall_o  - one-cycle pulse in the first cycle dout_o is 0
module debounce_ch
    import debounce_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = DEF_SYNC_STAGES,
    parameter int unsigned STABLE_CNT  = DEF_STABLE_CNT
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic din_i,
    output logic dout_o,
    output logic rise_o,
    output logic fall_o
);

    localparam int unsigned CW = cnt_w(STABLE_CNT);
    localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CNT - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic                   dout_q, dout_d;
    logic                   rise_q, rise_d;
    logic                   fall_q, fall_d;
    ch_state_e              state;

    // Pure flop chain: nothing combinational between stages so metastability
    // gets the full clock period to resolve at each stage.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], din_i};
        end
    end

    assign s = sync_q[SYNC_STAGES-1];

    always_comb begin
        state  = (s != dout_q) ? ST_PENDING : ST_STABLE;
        cnt_d  = '0;
        dout_d = dout_q;
        rise_d = 1'b0;
        fall_d = 1'b0;
        case (state)
            ST_PENDING: begin
                if (cnt_q == CNT_MAX) begin
                    // Mismatch held for STABLE_CNT edges: accept new level.
                    dout_d = s;
                    rise_d = s;
                    fall_d = ~s;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                // Any agreement discards the partial count.
                cnt_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q  <= '0;
            dout_q <= 1'b0;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            dout_q <= dout_d;
            rise_q <= rise_d;
            fall_q <= fall_d;
        end
    end

    assign dout_o = dout_q;
    assign rise_o = rise_q;
    assign fall_o = fall_q;

endmodule

// File: rtl/debounce_sync.sv
// debounce_sync
//   Synchronises and debounces N_CH independent raw inputs, producing clean
//   levels for downstream gate operands plus one-cycle edge strobes.
// Ports:
//   clk    - system clock, rising edge
//   rst_n  - asynchronous active-low reset
//   din    - raw asynchronous inputs [N_CH]
//   dout   - debounced levels [N_CH]
//   rise   - one-cycle pulse when dout[i] goes 0->1 [N_CH]
//   fall   - one-cycle pulse when dout[i] goes 1->0 [N_CH]
module debounce_sync
    import debounce_pkg::*;
#(
    parameter int unsigned N_CH        = 2,
    parameter int unsigned SYNC_STAGES = DEF_SYNC_STAGES,
    parameter int unsigned STABLE_CNT  = DEF_STABLE_CNT
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [N_CH-1:0] din,
    output logic [N_CH-1:0] dout,
    output logic [N_CH-1:0] rise,
    output logic [N_CH-1:0] fall
);

    if (STABLE_CNT < 2) begin : g_bad_stable_cnt
        $error("debounce_sync: STABLE_CNT must be at least 2");
    end

    if (SYNC_STAGES != 2 && SYNC_STAGES != 3) begin : g_bad_sync_stages
        $error("debounce_sync: SYNC_STAGES must be 2 or 3");
    end

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        debounce_ch #(
            .SYNC_STAGES(SYNC_STAGES),
            .STABLE_CNT (STABLE_CNT)
        ) u_ch (
            .clk_i (clk),
            .rst_ni(rst_n),
            .din_i (din[i]),
            .dout_o(dout[i]),
            .rise_o(rise[i]),
            .fall_o(fall[i])
        );
    end

endmodule
